fu_wb_arbiter: RTL and testbench

- Parametrised completion/writeback stage between the functional units (ALU lanes, load/store) and the ROB's single writeback port.
- Buffers each FU's result in a per-channel FIFO and arbitrates round-robin onto one registered ROB port.
- Honours ROB backpressure and returns per-channel ready to the FUs/RS.
- Replaces the fixed ALU-to-ROB wiring and the "ls_done & alu_done" stall hack with a general N-channel structure.

---
 rtl/fu_wb_arbiter_pkg.sv | 31 +++
 rtl/fu_wb_arbiter_if.sv | 41 ++++
 rtl/fu_wb_fifo.sv | 61 ++++++
 rtl/fu_wb_arbiter.sv | 131 +++++++++++++
 tb/tb_fu_wb_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types for the FU writeback arbiter: flag bundle, buffered result entry and width helper.
// Supplies default GPR/ROB index widths when the surrounding core has not defined them.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif

package fu_wb_arbiter_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic [`ROB_IDX_SIZE-1:0] dst_rob_index;
    logic [`GPR_SIZE-1:0]     value;
    logic                     set_nzcv;
    nzcv_t                    nzcv;
  } fu_wb_entry_t;

  // Channel index width, never narrower than one bit.
  function automatic int unsigned ch_idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// FU-side result channels and the single ROB writeback port of the arbiter.
// The slave modport is the arbiter's view; master is the FU/ROB environment.
interface fu_wb_arbiter_if #(
  parameter int unsigned NUM_CH = 2
) ();
  import fu_wb_arbiter_pkg::*;

  localparam int unsigned ChW = ch_idx_width(NUM_CH);

  logic [NUM_CH-1:0]                    in_fu_done;
  logic [NUM_CH-1:0][`ROB_IDX_SIZE-1:0] in_fu_dst_rob_index;
  logic [NUM_CH-1:0][`GPR_SIZE-1:0]     in_fu_value;
  logic [NUM_CH-1:0]                    in_fu_set_nzcv;
  nzcv_t [NUM_CH-1:0]                   in_fu_nzcv;
  logic [NUM_CH-1:0]                    out_fu_ready;

  logic                     in_rob_stall;
  logic                     out_rob_done;
  logic [`ROB_IDX_SIZE-1:0] out_rob_dst_rob_index;
  logic [`GPR_SIZE-1:0]     out_rob_value;
  logic                     out_rob_set_nzcv;
  nzcv_t                    out_rob_nzcv;
  logic [ChW-1:0]           out_rob_src_ch;

  modport master (
    output in_fu_done, in_fu_dst_rob_index, in_fu_value, in_fu_set_nzcv, in_fu_nzcv,
    output in_rob_stall,
    input  out_fu_ready,
    input  out_rob_done, out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv, out_rob_nzcv,
    input  out_rob_src_ch
  );

  modport slave (
    input  in_fu_done, in_fu_dst_rob_index, in_fu_value, in_fu_set_nzcv, in_fu_nzcv,
    input  in_rob_stall,
    output out_fu_ready,
    output out_rob_done, out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv, out_rob_nzcv,
    output out_rob_src_ch
  );

endinterface

// File: rtl/fu_wb_fifo.sv
// Per-channel result FIFO with synchronous reset; push is ignored when full, pop when empty.
// Read data is the current head entry, valid whenever empty is low.
module fu_wb_fifo
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fu_wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/fu_wb_arbiter.sv
// N-channel FU completion stage: per-channel FIFOs arbitrated onto one registered ROB port.
// Define FU_WB_FIXED_PRIO_EN for lowest-channel-first priority instead of round-robin.
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DEPTH  = 4
) (
  input logic            in_clk,
  input logic            in_rst,
  fu_wb_arbiter_if.slave bus
);

  localparam int unsigned ChW = ch_idx_width(NUM_CH);

  fu_wb_entry_t      fifo_wdata [NUM_CH];
  fu_wb_entry_t      fifo_rdata [NUM_CH];
  logic [NUM_CH-1:0] fifo_push;
  logic [NUM_CH-1:0] fifo_pop;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;

  logic           grant_valid;
  logic [ChW-1:0] grant;
  logic [ChW-1:0] grant_next;
  logic           rob_free;

  logic           done_q;
  fu_wb_entry_t   entry_q;
  logic [ChW-1:0] src_q;
`ifndef FU_WB_FIXED_PRIO_EN
  logic [ChW-1:0] rr_q;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign fifo_wdata[c] = '{
      dst_rob_index: bus.in_fu_dst_rob_index[c],
      value:         bus.in_fu_value[c],
      set_nzcv:      bus.in_fu_set_nzcv[c],
      nzcv:          bus.in_fu_nzcv[c]
    };
    assign fifo_push[c] = bus.in_fu_done[c];
    assign fifo_pop[c]  = rob_free && grant_valid && (grant == ChW'(c));

    fu_wb_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fu_wb_entry_t)
    ) u_fifo (
      .clk   (in_clk),
      .rst   (in_rst),
      .push  (fifo_push[c]),
      .pop   (fifo_pop[c]),
      .wdata (fifo_wdata[c]),
      .rdata (fifo_rdata[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  // Ready depends on occupancy only, so a full FIFO refuses input even on a popping cycle.
  assign bus.out_fu_ready = ~fifo_full;
  assign rob_free         = !done_q || !bus.in_rob_stall;

  always_comb begin
    int unsigned idx;
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef FU_WB_FIXED_PRIO_EN
      idx = i;
`else
      idx = 32'(rr_q) + i;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
`endif
      if (!grant_valid && !fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant       = ChW'(idx);
      end
    end
  end

  assign grant_next = (grant == ChW'(NUM_CH - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      done_q  <= 1'b0;
      entry_q <= '0;
      src_q   <= '0;
`ifndef FU_WB_FIXED_PRIO_EN
      rr_q    <= '0;
`endif
    end else if (rob_free) begin
      if (grant_valid) begin
        done_q  <= 1'b1;
        entry_q <= fifo_rdata[grant];
        src_q   <= grant;
`ifndef FU_WB_FIXED_PRIO_EN
        rr_q    <= grant_next;
`endif
      end else begin
        done_q <= 1'b0;
      end
    end
  end

  assign bus.out_rob_done          = done_q;
  assign bus.out_rob_dst_rob_index = entry_q.dst_rob_index;
  assign bus.out_rob_value         = entry_q.value;
  assign bus.out_rob_set_nzcv      = entry_q.set_nzcv;
  assign bus.out_rob_nzcv          = entry_q.nzcv;
  assign bus.out_rob_src_ch        = src_q;

  // A result offered to a full channel is lost; flag it loudly in simulation.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        assert (!(bus.in_fu_done[c] && fifo_full[c]))
          else $warning("fu_wb_arbiter: channel %0d done while not ready, entry dropped", c);
      end
    end
  end

  `ifdef FU_WB_FIXED_PRIO_EN
  logic unused_grant_next;
  assign unused_grant_next = ^grant_next;
  `endif

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Self-checking bench for fu_wb_arbiter: per-channel scoreboard plus scenario-specific checks.
// Honours FU_WB_FIXED_PRIO_EN for the expected cross-channel order.
module tb_fu_wb_arbiter;
  import fu_wb_arbiter_pkg::*;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;

  fu_wb_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

  fu_wb_arbiter #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH)
  ) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  fu_wb_entry_t     exp_q [NUM_CH][$];
  logic [63:0]      obs_vals [$];

  // Each cycle: retire a writeback accepted by the ROB against the scoreboard, then step a clock.
  task automatic tick();
    int           ch;
    fu_wb_entry_t got;
    fu_wb_entry_t want;
    @(negedge clk);
    if (!rst && bus.out_rob_done && !bus.in_rob_stall) begin
      ch                = int'(bus.out_rob_src_ch);
      got.dst_rob_index = bus.out_rob_dst_rob_index;
      got.value         = bus.out_rob_value;
      got.set_nzcv      = bus.out_rob_set_nzcv;
      got.nzcv          = bus.out_rob_nzcv;
      obs_vals.push_back(64'(bus.out_rob_value));
      vectors++;
      if (exp_q[ch].size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: ch %0d got %h, required no writeback", ch, got);
      end else begin
        want = exp_q[ch].pop_front();
        if (got !== want) begin
          miscompares++;
          $display("FAIL wb_data: ch %0d got %h, required %h", ch, got, want);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic [`ROB_IDX_SIZE-1:0] idx,
                       input logic [`GPR_SIZE-1:0] val, input logic set, input logic [3:0] nz,
                       input bit accept);
    fu_wb_entry_t e;
    bus.in_fu_done[ch]          = 1'b1;
    bus.in_fu_dst_rob_index[ch] = idx;
    bus.in_fu_value[ch]         = val;
    bus.in_fu_set_nzcv[ch]      = set;
    bus.in_fu_nzcv[ch]          = nz;
    e.dst_rob_index = idx;
    e.value         = val;
    e.set_nzcv      = set;
    e.nzcv          = nz;
    if (accept) exp_q[ch].push_back(e);
  endtask

  task automatic clear_inputs();
    bus.in_fu_done = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    bus.in_rob_stall = 1'b0;
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    obs_vals.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_rob_stall = 1'b0;
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    // Results offered on the reset edge must be ignored.
    drive(0, 6'd7, 64'd77, 1'b1, 4'hf, 1'b0);
    drive(1, 6'd8, 64'd88, 1'b1, 4'hf, 1'b0);
    tick();
    rst = 1'b0;
    clear_inputs();
    vectors++;
    if (bus.out_rob_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_done: got %b, required 0", bus.out_rob_done);
    end
    vectors++;
    if (bus.out_rob_dst_rob_index !== '0 || bus.out_rob_value !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got idx %0d value %0d, required 0 0",
               bus.out_rob_dst_rob_index, bus.out_rob_value);
    end
    vectors++;
    if (bus.out_rob_set_nzcv !== 1'b0 || bus.out_rob_nzcv !== 4'h0 || bus.out_rob_src_ch !== '0)
    begin
      miscompares++;
      $display("FAIL reset_flags: got set %b nzcv %b src %0d, required 0 0000 0",
               bus.out_rob_set_nzcv, bus.out_rob_nzcv, bus.out_rob_src_ch);
    end
    vectors++;
    if (bus.out_fu_ready !== 2'b11) begin
      miscompares++; $display("FAIL reset_ready: got %b, required 11", bus.out_fu_ready);
    end
    tick();
    tick();
    vectors++;
    if (bus.out_rob_done !== 1'b0) begin
      miscompares++; $display("FAIL reset_edge_input: got done %b, required 0", bus.out_rob_done);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 6'd5, 64'd42, 1'b1, 4'b0100, 1'b1);
    tick();
    clear_inputs();
    vectors++;
    if (bus.out_rob_done !== 1'b0) begin
      miscompares++; $display("FAIL single_early: got done %b, required 0", bus.out_rob_done);
    end
    tick();
    vectors++;
    if (bus.out_rob_done !== 1'b1 || bus.out_rob_dst_rob_index !== 6'd5 ||
        bus.out_rob_value !== 64'd42 || bus.out_rob_set_nzcv !== 1'b1 ||
        bus.out_rob_nzcv !== 4'b0100 || bus.out_rob_src_ch !== 1'b0) begin
      miscompares++;
      $display("FAIL single_wb: got done %b idx %0d val %0d set %b nzcv %b src %0d, required 1 5 42 1 0100 0",
               bus.out_rob_done, bus.out_rob_dst_rob_index, bus.out_rob_value,
               bus.out_rob_set_nzcv, bus.out_rob_nzcv, bus.out_rob_src_ch);
    end
    tick();
    vectors++;
    if (bus.out_rob_done !== 1'b0) begin
      miscompares++; $display("FAIL single_after: got done %b, required 0", bus.out_rob_done);
    end
  endtask

  task automatic test_round_robin();
    logic [63:0] order [6];
`ifdef FU_WB_FIXED_PRIO_EN
    order = '{64'd1, 64'd2, 64'd3, 64'd101, 64'd102, 64'd103};
`else
    order = '{64'd1, 64'd101, 64'd2, 64'd102, 64'd3, 64'd103};
`endif
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(0, 6'(k), 64'(k), 1'b0, 4'h1, 1'b1);
      drive(1, 6'(20 + k), 64'(100 + k), 1'b1, 4'h2, 1'b1);
      tick();
    end
    clear_inputs();
    for (int k = 0; k < 10; k++) tick();
    vectors++;
    if (obs_vals.size() != 6) begin
      miscompares++; $display("FAIL rr_count: got %0d writebacks, required 6", obs_vals.size());
    end
    for (int k = 0; k < 6; k++) begin
      if (k < obs_vals.size()) begin
        vectors++;
        if (obs_vals[k] !== order[k]) begin
          miscompares++;
          $display("FAIL rr_order[%0d]: got %0d, required %0d", k, obs_vals[k], order[k]);
        end
      end
    end
  endtask

  task automatic test_stall_full();
    do_reset();
    bus.in_rob_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 6'(10 + k), 64'(300 + k), 1'b0, 4'(k), 1'b1);
      tick();
      vectors++;
      if (bus.out_fu_ready[1] !== (k < 4)) begin
        miscompares++;
        $display("FAIL stall_ready[%0d]: got %b, required %b", k, bus.out_fu_ready[1], k < 4);
      end
      if (k >= 1) begin
        vectors++;
        if (bus.out_rob_done !== 1'b1 || bus.out_rob_value !== 64'd300 ||
            bus.out_rob_dst_rob_index !== 6'd10 || bus.out_rob_src_ch !== 1'b1) begin
          miscompares++;
          $display("FAIL stall_hold[%0d]: got done %b val %0d idx %0d, required 1 300 10",
                   k, bus.out_rob_done, bus.out_rob_value, bus.out_rob_dst_rob_index);
        end
      end
    end
    clear_inputs();
    tick();
    tick();
    vectors++;
    if (bus.out_rob_value !== 64'd300 || bus.out_fu_ready[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_idle: got val %0d ready %b, required 300 0",
               bus.out_rob_value, bus.out_fu_ready[1]);
    end
    // Release stall while offering to the full channel: the offer must be refused.
    bus.in_rob_stall = 1'b0;
    drive(1, 6'd63, 64'd999, 1'b0, 4'h0, 1'b0);
    vectors++;
    if (bus.out_fu_ready[1] !== 1'b0) begin
      miscompares++; $display("FAIL full_pop_ready: got %b, required 0", bus.out_fu_ready[1]);
    end
    tick();
    clear_inputs();
    vectors++;
    if (bus.out_fu_ready[1] !== 1'b1 || bus.out_rob_value !== 64'd301) begin
      miscompares++;
      $display("FAIL full_pop_after: got ready %b val %0d, required 1 301",
               bus.out_fu_ready[1], bus.out_rob_value);
    end
    for (int k = 0; k < 8; k++) tick();
    vectors++;
    if (exp_q[1].size() != 0 || bus.out_rob_done !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_drain: got %0d pending done %b, required 0 0",
               exp_q[1].size(), bus.out_rob_done);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    bus.in_rob_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(0, 6'(30 + k), 64'(400 + k), 1'b1, 4'h8, 1'b1);
      tick();
    end
    clear_inputs();
    bus.in_rob_stall = 1'b0;
    tick();
    rst = 1'b1;
    for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.out_rob_done !== 1'b0 || bus.out_fu_ready !== 2'b11 || bus.out_rob_value !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got done %b ready %b val %0d, required 0 11 0",
               bus.out_rob_done, bus.out_fu_ready, bus.out_rob_value);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if (bus.out_rob_done !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_reset_stale[%0d]: got done %b val %0d, required 0",
                 k, bus.out_rob_done, bus.out_rob_value);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(0, 6'(i), 64'(500 + i), 1'(i), 4'(i), 1'b1);
      else clear_inputs();
      tick();
      if (i >= 1) begin
        vectors++;
        if (bus.out_rob_done !== 1'b1 || bus.out_rob_value !== 64'(500 + i - 1)) begin
          miscompares++;
          $display("FAIL wrap_latency[%0d]: got done %b val %0d, required 1 %0d",
                   i, bus.out_rob_done, bus.out_rob_value, 500 + i - 1);
        end
      end
    end
    tick();
    tick();
    vectors++;
    if (exp_q[0].size() != 0) begin
      miscompares++; $display("FAIL wrap_drain: got %0d pending, required 0", exp_q[0].size());
    end
  endtask

  initial begin
    rst                     = 1'b1;
    bus.in_fu_done          = '0;
    bus.in_fu_dst_rob_index = '0;
    bus.in_fu_value         = '0;
    bus.in_fu_set_nzcv      = '0;
    bus.in_fu_nzcv          = '0;
    bus.in_rob_stall        = 1'b0;
    tick();
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_stall_full();
    test_reset_mid_drain();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
